// File: rtl/miner_pkg.sv
// Shared widths, FSM state encoding and the nonce byte-order helper
// used by the nonce scanner.
package miner_pkg;

  localparam int HEADER_W = 608;
  localparam int TARGET_W = 256;
  localparam int NONCE_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RELEASE,
    ST_DRAIN
  } state_t;

  // The block header carries the nonce little-endian.
  function automatic logic [NONCE_W-1:0] byteswap32(input logic [NONCE_W-1:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/hash_le_target.sv
// Unsigned 256-bit difficulty check: asserts le when hash <= target.
module hash_le_target
  import miner_pkg::*;
(
  input  logic [TARGET_W-1:0] hash,
  input  logic [TARGET_W-1:0] target,
  output logic                le
);

  assign le = (hash <= target);

endmodule

// File: rtl/nonce_scanner.sv
// Walks a nonce range through an external sha256 core using a start/ready
// handshake, compares each result against the target and reports hits.
module nonce_scanner
  import miner_pkg::*;
#(
  parameter bit STOP_ON_FOUND = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                job_valid,
  input  logic [HEADER_W-1:0] job_header,
  input  logic [TARGET_W-1:0] job_target,
  input  logic [NONCE_W-1:0]  nonce_first,
  input  logic [NONCE_W-1:0]  nonce_last,
  input  logic                abort,
  output logic                core_start,
  output logic [HEADER_W+NONCE_W-1:0] core_data,
  input  logic [TARGET_W-1:0] core_hash,
  input  logic                core_ready,
  output logic                busy,
  output logic                found_valid,
  output logic [NONCE_W-1:0]  found_nonce,
  output logic                done,
  output logic [2:0]          status,
  output logic [31:0]         hash_count
);

  state_t              state;
  logic [HEADER_W-1:0] header_q;
  logic [TARGET_W-1:0] target_q;
  logic [NONCE_W-1:0]  nonce_q;
  logic [NONCE_W-1:0]  last_q;
  logic                hit_q;
  logic                abort_q;
  logic                drain_seen_q;
  logic                hash_le;

  hash_le_target u_cmp (
    .hash   (core_hash),
    .target (target_q),
    .le     (hash_le)
  );

  assign core_data = {header_q, byteswap32(nonce_q)};

  // status is {aborted, exhausted, found}; done and found_valid are single-cycle pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      header_q     <= '0;
      target_q     <= '0;
      nonce_q      <= '0;
      last_q       <= '0;
      hit_q        <= 1'b0;
      abort_q      <= 1'b0;
      drain_seen_q <= 1'b0;
      core_start   <= 1'b0;
      busy         <= 1'b0;
      found_valid  <= 1'b0;
      found_nonce  <= '0;
      done         <= 1'b0;
      status       <= 3'b000;
      hash_count   <= '0;
    end else begin
      found_valid <= 1'b0;
      done        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (job_valid && !abort) begin
            header_q   <= job_header;
            target_q   <= job_target;
            nonce_q    <= nonce_first;
            last_q     <= nonce_last;
            hit_q      <= 1'b0;
            abort_q    <= 1'b0;
            status     <= 3'b000;
            hash_count <= '0;
            core_start <= 1'b1;
            busy       <= 1'b1;
            state      <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          // Abort wins over a simultaneous result; the core still has to be drained.
          if (abort) begin
            core_start   <= 1'b0;
            drain_seen_q <= core_ready;
            state        <= ST_DRAIN;
          end else if (core_ready) begin
            core_start <= 1'b0;
            hit_q      <= hash_le;
            abort_q    <= 1'b0;
            hash_count <= hash_count + 32'd1;
            if (hash_le) begin
              found_valid <= 1'b1;
              found_nonce <= nonce_q;
              status[0]   <= 1'b1;
            end
            state <= ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          if (abort) begin
            abort_q <= 1'b1;
          end
          if (!core_ready) begin
            if (abort || abort_q) begin
              status[2] <= 1'b1;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= ST_IDLE;
            end else if (hit_q && STOP_ON_FOUND) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_IDLE;
            end else if (nonce_q == last_q) begin
              status[1] <= 1'b1;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              nonce_q    <= nonce_q + 32'd1;
              core_start <= 1'b1;
              state      <= ST_ISSUE;
            end
          end
        end

        ST_DRAIN: begin
          if (!drain_seen_q) begin
            if (core_ready) begin
              drain_seen_q <= 1'b1;
            end
          end else if (!core_ready) begin
            drain_seen_q <= 1'b0;
            status[2]    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b1;
            state        <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_scanner.sv
// Bench for nonce_scanner: two instances (stop-on-found and full-scan), each paired
// with a behavioural sha256 core of programmable latency, checked against a range-walk model.
module tb_nonce_scanner;

  logic         clk = 1'b0;
  logic         reset;
  logic [607:0] job_header;
  logic [255:0] job_target;
  logic [31:0]  nonce_first;
  logic [31:0]  nonce_last;

  logic         job_valid   [2];
  logic         abort       [2];
  logic         core_start  [2];
  logic [639:0] core_data   [2];
  logic [255:0] core_hash   [2];
  logic         core_ready  [2];
  logic         busy        [2];
  logic         found_valid [2];
  logic [31:0]  found_nonce [2];
  logic         done        [2];
  logic [2:0]   status      [2];
  logic [31:0]  hash_count  [2];

  int           latency;
  int           hash_mode;
  logic [255:0] hit_mask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nonce_scanner #(.STOP_ON_FOUND(1'b1)) u_dut_stop (
    .clk(clk), .reset(reset), .job_valid(job_valid[0]), .job_header(job_header),
    .job_target(job_target), .nonce_first(nonce_first), .nonce_last(nonce_last),
    .abort(abort[0]), .core_start(core_start[0]), .core_data(core_data[0]),
    .core_hash(core_hash[0]), .core_ready(core_ready[0]), .busy(busy[0]),
    .found_valid(found_valid[0]), .found_nonce(found_nonce[0]), .done(done[0]),
    .status(status[0]), .hash_count(hash_count[0])
  );

  nonce_scanner #(.STOP_ON_FOUND(1'b0)) u_dut_all (
    .clk(clk), .reset(reset), .job_valid(job_valid[1]), .job_header(job_header),
    .job_target(job_target), .nonce_first(nonce_first), .nonce_last(nonce_last),
    .abort(abort[1]), .core_start(core_start[1]), .core_data(core_data[1]),
    .core_hash(core_hash[1]), .core_ready(core_ready[1]), .busy(busy[1]),
    .found_valid(found_valid[1]), .found_nonce(found_nonce[1]), .done(done[1]),
    .status(status[1]), .hash_count(hash_count[1])
  );

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Mode 1 hits exactly on masked nonces, sitting on the target boundary either way.
  function automatic logic [255:0] model_hash(input logic [639:0] d);
    logic [31:0]  n;
    logic [31:0]  x;
    logic [255:0] h;
    n = bswap(d[31:0]);
    if (hash_mode == 1) return hit_mask[n[7:0]] ? job_target : job_target + 256'd1;
    x = n ^ d[63:32] ^ d[639:608];
    for (int i = 0; i < 8; i++) begin
      x = x * 32'h9E3779B1 + 32'h7F4A7C15 + 32'(i);
      x = x ^ (x >> 15);
      h[32*i +: 32] = x;
    end
    return h;
  endfunction

  logic         core_run [2];
  int           core_cnt [2];
  logic [639:0] core_lat [2];

  always @(posedge clk or posedge reset) begin
    for (int g = 0; g < 2; g++) begin
      if (reset) begin
        core_ready[g] <= 1'b0;
        core_run[g]   <= 1'b0;
        core_cnt[g]   <= 0;
        core_hash[g]  <= '0;
        core_lat[g]   <= '0;
      end else if (core_run[g]) begin
        if (core_cnt[g] <= 1) begin
          core_run[g]   <= 1'b0;
          core_ready[g] <= 1'b1;
          core_hash[g]  <= model_hash(core_lat[g]);
        end else begin
          core_cnt[g] <= core_cnt[g] - 1;
        end
      end else if (core_ready[g]) begin
        if (!core_start[g]) core_ready[g] <= 1'b0;
      end else if (core_start[g]) begin
        core_run[g] <= 1'b1;
        core_cnt[g] <= latency;
        core_lat[g] <= core_data[g];
      end
    end
  end

  logic [31:0] issued_log [2][1024];
  int          issued_n   [2];
  logic [31:0] found_log  [2][256];
  int          found_n    [2];
  int          done_n     [2];
  logic        start_prev [2];
  int          viol_n = 0;
  int          hdr_bad_n = 0;

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (core_start[g] === 1'b1 && start_prev[g] !== 1'b1) begin
        if (core_ready[g] === 1'b1) viol_n++;
        if (core_data[g][639:32] !== job_header) hdr_bad_n++;
        if (issued_n[g] < 1024) issued_log[g][issued_n[g]] = bswap(core_data[g][31:0]);
        issued_n[g]++;
      end
      if (found_valid[g] === 1'b1) begin
        if (found_n[g] < 256) found_log[g][found_n[g]] = found_nonce[g];
        found_n[g]++;
      end
      if (done[g] === 1'b1) done_n[g]++;
      start_prev[g] = core_start[g];
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic startJob(input int g, input logic [31:0] first, input logic [31:0] last,
                          input logic [255:0] tgt);
    for (int i = 0; i < 19; i++) job_header[32*i +: 32] = $urandom;
    job_target  = tgt;
    nonce_first = first;
    nonce_last  = last;
    job_valid[g] = 1'b1;
    tick();
    job_valid[g] = 1'b0;
  endtask

  task automatic waitDone(input int g, input int bd, input int budget, input string tag,
                          output int waited);
    waited = 0;
    while (done_n[g] == bd && waited < budget) begin
      tick();
      waited++;
    end
    if (done_n[g] == bd) checkOutput({tag, "_timeout"}, 64'(0), 64'(1));
  endtask

  task automatic checkIdleZero(input int g, input string tag);
    checkOutput({tag, "_busy"},        64'(busy[g]),        64'(0));
    checkOutput({tag, "_core_start"},  64'(core_start[g]),  64'(0));
    checkOutput({tag, "_found_valid"}, 64'(found_valid[g]), 64'(0));
    checkOutput({tag, "_done"},        64'(done[g]),        64'(0));
    checkOutput({tag, "_status"},      64'(status[g]),      64'(0));
    checkOutput({tag, "_hash_count"},  64'(hash_count[g]),  64'(0));
    checkOutput({tag, "_found_nonce"}, 64'(found_nonce[g]), 64'(0));
  endtask

  // Run one job to completion and compare against the range-walk model.
  task automatic applyStimulus(input int g, input logic [31:0] first, input logic [31:0] last,
                               input logic [255:0] tgt, input string tag);
    int          bi, bf, bd, waited, cnt, got_n;
    logic [31:0] n;
    logic [2:0]  st;
    logic [31:0] exp_iss[$];
    logic [31:0] exp_fnd[$];
    bi = issued_n[g];
    bf = found_n[g];
    bd = done_n[g];
    startJob(g, first, last, tgt);
    waitDone(g, bd, 3000, tag, waited);
    repeat (3) tick();

    n = first; st = 3'b000; cnt = 0;
    while (cnt < 1000) begin
      exp_iss.push_back(n);
      cnt++;
      if (model_hash({job_header, bswap(n)}) <= job_target) begin
        exp_fnd.push_back(n);
        st[0] = 1'b1;
        if (g == 0) break;
      end
      if (n == last) begin
        st[1] = 1'b1;
        break;
      end
      n = n + 32'd1;
    end

    got_n = issued_n[g] - bi;
    checkOutput({tag, "_issue_count"}, 64'(got_n), 64'(exp_iss.size()));
    for (int i = 0; i < exp_iss.size() && i < got_n; i++)
      checkOutput($sformatf("%s_nonce%0d", tag, i), 64'(issued_log[g][bi+i]), 64'(exp_iss[i]));
    got_n = found_n[g] - bf;
    checkOutput({tag, "_found_count"}, 64'(got_n), 64'(exp_fnd.size()));
    for (int i = 0; i < exp_fnd.size() && i < got_n; i++)
      checkOutput($sformatf("%s_found%0d", tag, i), 64'(found_log[g][bf+i]), 64'(exp_fnd[i]));
    if (exp_fnd.size() > 0)
      checkOutput({tag, "_found_nonce"}, 64'(found_nonce[g]), 64'(exp_fnd[exp_fnd.size()-1]));
    checkOutput({tag, "_status"},     64'(status[g]),       64'(st));
    checkOutput({tag, "_hash_count"}, 64'(hash_count[g]),   64'(cnt));
    checkOutput({tag, "_done_count"}, 64'(done_n[g] - bd),  64'(1));
    checkOutput({tag, "_busy"},       64'(busy[g]),         64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          bi, bf, bd, waited, len, g;
    logic [31:0] first;
    logic [255:0] tgt;

    reset = 1'b1;
    job_header = '0; job_target = '0; nonce_first = '0; nonce_last = '0;
    latency = 3; hash_mode = 0; hit_mask = '0;
    for (int i = 0; i < 2; i++) begin
      job_valid[i] = 1'b0;
      abort[i]     = 1'b0;
    end
    repeat (3) tick();
    checkIdleZero(0, "reset_stop");
    checkIdleZero(1, "reset_all");
    reset = 1'b0;
    tick();

    $display("[TB] single nonce, target all-ones");
    applyStimulus(0, 32'd5, 32'd5, '1, "one_hash");
    checkOutput("one_hash_fixed_nonce",  64'(found_nonce[0]), 64'(5));
    checkOutput("one_hash_fixed_status", 64'(status[0]),      64'(3'b001));

    $display("[TB] range 0..3, target zero");
    applyStimulus(0, 32'd0, 32'd3, '0, "no_hit");
    checkOutput("no_hit_fixed_status", 64'(status[0]), 64'(3'b010));

    $display("[TB] wrap through 0xFFFFFFFF");
    applyStimulus(0, 32'hFFFFFFFE, 32'h00000001, '0, "wrap");

    $display("[TB] boundary hits on nonces 2 and 5");
    hash_mode = 1;
    hit_mask = '0;
    hit_mask[2] = 1'b1;
    hit_mask[5] = 1'b1;
    for (int i = 0; i < 8; i++) tgt[32*i +: 32] = $urandom;
    tgt[255] = 1'b0;
    applyStimulus(1, 32'd0, 32'd7, tgt, "all_hits");
    checkOutput("all_hits_fixed_status", 64'(status[1]),     64'(3'b011));
    checkOutput("all_hits_fixed_count",  64'(hash_count[1]), 64'(8));
    applyStimulus(0, 32'd0, 32'd7, tgt, "stop_hit");
    hash_mode = 0;

    $display("[TB] abort during a long hash");
    latency = 70;
    bi = issued_n[0]; bf = found_n[0]; bd = done_n[0];
    startJob(0, 32'd0, 32'd9, '1);
    repeat (2) tick();
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    checkOutput("abort_start_low", 64'(core_start[0]), 64'(0));
    waitDone(0, bd, 500, "abort_issue", waited);
    checkOutput("abort_drain_wait", 64'(waited >= 60), 64'(1));
    repeat (10) tick();
    checkOutput("abort_status",      64'(status[0]),        64'(3'b100));
    checkOutput("abort_hash_count",  64'(hash_count[0]),    64'(0));
    checkOutput("abort_found_count", 64'(found_n[0] - bf),  64'(0));
    checkOutput("abort_issue_count", 64'(issued_n[0] - bi), 64'(1));
    checkOutput("abort_done_count",  64'(done_n[0] - bd),   64'(1));

    $display("[TB] abort together with core_ready");
    latency = 4;
    bf = found_n[1]; bd = done_n[1];
    startJob(1, 32'd0, 32'd9, '1);
    waited = 0;
    while (core_ready[1] !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    abort[1] = 1'b1;
    tick();
    abort[1] = 1'b0;
    waitDone(1, bd, 200, "abort_ready", waited);
    repeat (3) tick();
    checkOutput("abort_ready_status",      64'(status[1]),       64'(3'b100));
    checkOutput("abort_ready_hash_count",  64'(hash_count[1]),   64'(0));
    checkOutput("abort_ready_found_count", 64'(found_n[1] - bf), 64'(0));

    $display("[TB] reset while in RELEASE");
    latency = 5;
    bd = done_n[0];
    startJob(0, 32'd0, 32'd9, '0);
    waited = 0;
    while (core_ready[0] !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    tick();
    checkOutput("rst_pre_busy",       64'(busy[0]),       64'(1));
    checkOutput("rst_pre_hash_count", 64'(hash_count[0]), 64'(1));
    reset = 1'b1;
    #1;
    checkIdleZero(0, "rst_mid");
    tick();
    tick();
    reset = 1'b0;
    repeat (3) tick();
    checkOutput("rst_no_done", 64'(done_n[0] - bd), 64'(0));
    applyStimulus(0, 32'd5, 32'd5, '1, "after_reset");
    checkOutput("after_reset_fixed_nonce", 64'(found_nonce[0]), 64'(5));

    $display("[TB] randomized ranges and targets");
    for (int k = 0; k < 8; k++) begin
      g       = k % 2;
      latency = $urandom_range(1, 6);
      first   = $urandom;
      if (k % 3 == 0) first = 32'hFFFFFFFF - 32'($urandom_range(0, 4));
      len = $urandom_range(0, 12);
      for (int i = 0; i < 7; i++) tgt[32*i +: 32] = $urandom;
      tgt[255:224] = 32'($urandom_range(0, 32'h60000000));
      applyStimulus(g, first, first + 32'(len), tgt, $sformatf("rnd%0d", k));
    end

    checkOutput("start_vs_ready", 64'(viol_n),    64'(0));
    checkOutput("header_field",   64'(hdr_bad_n), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nonce_scanner.md
NONCE_SCANNER -- requirements
Module: nonce_scanner

Interface
REQ-001 STOP_ON_FOUND, 1, 1 = end the job at the first hit; 0 = report every hit and scan the full range.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 job_valid  input  1  start a job; sampled only in IDLE.
REQ-005 job_header  input  608  first 76 header bytes, MSB-first; captured on job acceptance.
REQ-006 job_target  input  256  unsigned target; captured on job acceptance.
REQ-007 nonce_first  input  32  first nonce of the range.
REQ-008 nonce_last  input  32  last nonce of the range, inclusive.
REQ-009 abort  input  1  terminate the current job.
REQ-010 core_start  output  1  start request to the sha256 core.
REQ-011 core_data  output  640  {header, byteswap32(nonce)}; the nonce occupies bits 31:0.
REQ-012 core_hash  input  256  hash result from the core.
REQ-013 core_ready  input  1  result valid; the core holds it high until core_start falls.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 found_valid  output  1  one-cycle pulse on a hit.
REQ-016 found_nonce  output  32  nonce of the most recent hit; holds its value.
REQ-017 done  output  1  one-cycle pulse on return to IDLE.
REQ-018 status  output  3  {aborted, exhausted, found}; held until the next job is accepted.
REQ-019 hash_count  output  32  completed hashes in the current job; wraps modulo 2^32.

Function
REQ-020 States SHALL be IDLE, ISSUE, RELEASE and DRAIN.
REQ-021 IDLE with job_valid=1 and abort=0 SHALL do all of the following:
- capture header, target and the range; set nonce to nonce_first;
- clear status and hash_count;
- enter ISSUE, with core_start=1 on the following cycle.
REQ-022 In IDLE, job_valid together with abort SHALL be ignored, and job_valid SHALL be ignored in every non-IDLE state.
REQ-023 ISSUE SHALL hold core_start=1 and core_data stable until core_ready=1 is sampled.
REQ-024 When core_ready=1 is sampled in ISSUE, the block SHALL do all of the following:
- register core_hash <= target as an unsigned 256-bit compare;
- drop core_start on the next cycle;
- increment hash_count;
- enter RELEASE.
REQ-025 A hit SHALL pulse found_valid, load found_nonce and set status.found, in the same cycle that core_start falls.
REQ-026 RELEASE SHALL keep core_start=0 until core_ready=0 is sampled, and then take the first applicable exit:
- hit with STOP_ON_FOUND=1 -> IDLE;
- nonce==nonce_last -> IDLE with status.exhausted=1;
- otherwise -> nonce=nonce+1 (mod 2^32), then ISSUE.
REQ-027 When nonce_first>nonce_last, the scan SHALL wrap through 0xFFFFFFFF to 0; nonce_first==nonce_last SHALL produce exactly one hash.
REQ-028 abort in RELEASE SHALL take effect at the RELEASE exit: go to IDLE with status.aborted=1 and issue no new hash.
REQ-029 abort in ISSUE SHALL:
- drop core_start and enter DRAIN;
- DRAIN waits for core_ready=1, then core_ready=0, then goes to IDLE with status.aborted=1;
- no compare and no hash_count update for that hash.
REQ-030 If core_ready=1 is sampled in ISSUE in the same cycle as abort, abort SHALL take priority.
REQ-031 done SHALL pulse exactly once per accepted job, in the first cycle back in IDLE, with status already valid.
REQ-032 core_start SHALL never rise while core_ready=1.

Reset
REQ-033 Reset SHALL force state=IDLE and clear the following:
- core_start, found_valid, done, busy = 0;
- status = 0, hash_count = 0, found_nonce = 0;
- the captured header, target and nonce registers.
REQ-034 Reset asserted mid-job SHALL abandon the job with no done pulse; the core is reset by the same signal.

Structure
REQ-035 miner_pkg SHALL hold:
- HEADER_W=608, TARGET_W=256, NONCE_W=32;
- the state enum;
- the byteswap32 function.
REQ-036 The 256-bit compare SHALL be the sub-module hash_le_target (combinational, output is hash<=target).
REQ-037 The bench SHALL pair this block with a behavioural sha256 core model whose latency is programmable.

Verification
REQ-038 Range 5..5, target all-ones -> one hash; found_valid with found_nonce=5; status=001; hash_count=1; done.
REQ-039 Range 0..3, target 0 -> four hashes; no found_valid; status=010; hash_count=4.
REQ-040 Range 0xFFFFFFFE..0x00000001 -> nonces FFFFFFFE, FFFFFFFF, 0, 1 in that order; status=010; hash_count=4.
REQ-041 STOP_ON_FOUND=0, model hits on nonces 2 and 5 of 0..7 -> found_valid twice (2, then 5); status=011; hash_count=8.
REQ-042 abort asserted 3 cycles into ISSUE with core latency 70 -> DRAIN completes the core handshake; status=100; no found_valid; done once; core_start stays 0 while core_ready=1.
REQ-043 reset asserted in RELEASE -> all outputs 0 immediately; a new job afterward behaves as in REQ-038.
